// File: rtl/sram_share_arbiter.sv
// rtl/sram_share_arbiter.sv - two-port arbiter/sequencer sharing one single-port SRAM macro
// Same-cycle grant, 1-cycle read return routed to the owning port, bounded port-B starvation.
module sram_share_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MW       = 4,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          a_req_i,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_wdata_i,
  input  logic [MW-1:0] a_wmask_i,
  output logic          a_gnt_o,
  output logic          a_rvalid_o,
  output logic [DW-1:0] a_rdata_o,
  input  logic          b_req_i,
  input  logic          b_we_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [DW-1:0] b_wdata_i,
  input  logic [MW-1:0] b_wmask_i,
  output logic          b_gnt_o,
  output logic          b_rvalid_o,
  output logic [DW-1:0] b_rdata_o,
  output logic          csb_o,
  output logic          web_o,
  output logic [MW-1:0] wmask_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  input  logic [DW-1:0] rdata_i
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_own_q, rd_own_d;
  logic       b_starved;

  always_comb begin
    b_starved  = (wait_cnt_q == MaxWait);
    // B only beats a concurrent A request once it has been denied MAX_WAIT times in a row
    a_gnt_o    = ~rst_i & a_req_i & ~(b_req_i & b_starved);
    b_gnt_o    = ~rst_i & b_req_i & (~a_req_i | b_starved);

    csb_o      = 1'b1;
    web_o      = 1'b1;
    wmask_o    = '0;
    addr_o     = '0;
    wdata_o    = '0;
    if (a_gnt_o) begin
      csb_o    = 1'b0;
      web_o    = ~a_we_i;
      wmask_o  = a_wmask_i;
      addr_o   = a_addr_i;
      wdata_o  = a_wdata_i;
    end else if (b_gnt_o) begin
      csb_o    = 1'b0;
      web_o    = ~b_we_i;
      wmask_o  = b_wmask_i;
      addr_o   = b_addr_i;
      wdata_o  = b_wdata_i;
    end

    wait_cnt_d = wait_cnt_q;
    if (!b_req_i || b_gnt_o) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MaxWait) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    rd_pend_d  = (a_gnt_o & ~a_we_i) | (b_gnt_o & ~b_we_i);
    rd_own_d   = b_gnt_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_own_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_own_q   <= rd_own_d;
    end
  end

  assign a_rvalid_o = rd_pend_q & ~rd_own_q;
  assign b_rvalid_o = rd_pend_q & rd_own_q;
  assign a_rdata_o  = rdata_i;
  assign b_rdata_o  = rdata_i;

endmodule

// File: tb/tb_sram_share_arbiter.sv
// tb/tb_sram_share_arbiter.sv - self-checking bench for sram_share_arbiter
// SRAM behavioural model plus a read-return scoreboard fed from observed grants.
module tb_sram_share_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        a_req_i, a_we_i, b_req_i, b_we_i;
  logic [9:0]  a_addr_i, b_addr_i, addr_o;
  logic [31:0] a_wdata_i, b_wdata_i, wdata_o, a_rdata_o, b_rdata_o;
  logic [3:0]  a_wmask_i, b_wmask_i, wmask_o;
  logic        a_gnt_o, a_rvalid_o, b_gnt_o, b_rvalid_o, csb_o, web_o;
  logic [31:0] rdata_i = '0;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  logic [32:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk_i = ~clk_i;

  sram_share_arbiter #(.AW(10), .DW(32), .MW(4), .MAX_WAIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_req_i(a_req_i), .a_we_i(a_we_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
    .a_wmask_i(a_wmask_i), .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o),
    .b_req_i(b_req_i), .b_we_i(b_we_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
    .b_wmask_i(b_wmask_i), .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o),
    .csb_o(csb_o), .web_o(web_o), .wmask_o(wmask_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .rdata_i(rdata_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Single-port macro: one command per cycle, read data registered.
  always @(posedge clk_i) begin
    if (!csb_o) begin
      if (!web_o) begin
        for (int b = 0; b < 4; b++)
          if (wmask_o[b]) mem[addr_o][b*8 +: 8] = wdata_o[b*8 +: 8];
      end else begin
        rdata_i <= mem[addr_o];
      end
    end
  end

  // Scoreboard: every observed read grant owes exactly one return on the next cycle.
  always @(negedge clk_i) begin
    logic        sel_b, we;
    logic [9:0]  ad;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic [32:0] e;
    if (rst_i) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rv_owner", {a_rvalid_o, b_rvalid_o}, e[32] ? 2'b01 : 2'b10);
        chk("rdata", e[32] ? b_rdata_o : a_rdata_o, e[31:0]);
      end else begin
        chk("rv_idle", {a_rvalid_o, b_rvalid_o}, 2'b00);
      end
      chk("gnt_onehot", a_gnt_o & b_gnt_o, 0);
      if (a_gnt_o || b_gnt_o) begin
        sel_b = b_gnt_o;
        we = sel_b ? b_we_i    : a_we_i;
        ad = sel_b ? b_addr_i  : a_addr_i;
        wd = sel_b ? b_wdata_i : a_wdata_i;
        wm = sel_b ? b_wmask_i : a_wmask_i;
        chk("cmd", {csb_o, web_o, addr_o, wmask_o, wdata_o}, {1'b0, ~we, ad, wm, wd});
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (wm[b]) ref_mem[ad][b*8 +: 8] = wd[b*8 +: 8];
        end else begin
          exp_q.push_back({sel_b, ref_mem[ad]});
        end
      end else begin
        chk("idle_cmd", {csb_o, web_o, addr_o, wmask_o, wdata_o}, {1'b1, 1'b1, 46'd0});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drv_a(input logic req, input logic we, input logic [9:0] ad,
                       input logic [31:0] d, input logic [3:0] m);
    a_req_i = req; a_we_i = we; a_addr_i = ad; a_wdata_i = d; a_wmask_i = m;
  endtask

  task automatic drv_b(input logic req, input logic we, input logic [9:0] ad,
                       input logic [31:0] d, input logic [3:0] m);
    b_req_i = req; b_we_i = we; b_addr_i = ad; b_wdata_i = d; b_wmask_i = m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem[10'h010] = 32'h1111_1111; ref_mem[10'h010] = 32'h1111_1111;
    mem[10'h020] = 32'h2222_2222; ref_mem[10'h020] = 32'h2222_2222;

    rst_i = 1'b1;
    drv_a(1, 0, 10'h000, 0, 4'hF);
    drv_b(1, 0, 10'h001, 0, 4'hF);
    @(negedge clk_i);
    chk("rst_gnt", {a_gnt_o, b_gnt_o}, 2'b00);
    chk("rst_cmd", {csb_o, web_o, wmask_o, addr_o, wdata_o}, {1'b1, 1'b1, 46'd0});
    chk("rst_rv", {a_rvalid_o, b_rvalid_o}, 2'b00);
    chk("rst_wait", dut.wait_cnt_q, 0);
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rel_gnt", {a_gnt_o, b_gnt_o}, 2'b10);

    tick();
    drv_b(0, 0, 0, 0, 0);
    drv_a(1, 1, 10'h005, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk_i);
    chk("aw_cmd", {a_gnt_o, csb_o, web_o}, 3'b100);
    tick();
    drv_a(1, 0, 10'h005, 0, 4'hF);
    @(negedge clk_i);
    chk("ar_cmd", {a_gnt_o, csb_o, web_o}, 3'b101);
    tick();
    drv_a(0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("ar_ret", {a_rvalid_o, b_rvalid_o, a_rdata_o}, {2'b10, 32'hDEAD_BEEF});

    tick();
    drv_a(1, 0, 10'h040, 0, 4'hF);
    drv_b(1, 0, 10'h100, 0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("cont_gnt", {a_gnt_o, b_gnt_o}, (i % 5 == 4) ? 2'b01 : 2'b10);
      if (i == 4) chk("cont_wait_sat", dut.wait_cnt_q, 4);
      if (i == 5) chk("cont_wait_clr", dut.wait_cnt_q, 0);
      if (i < 9) tick();
    end

    tick();
    drv_b(0, 0, 0, 0, 0);
    drv_a(1, 0, 10'h010, 0, 4'hF);
    @(negedge clk_i);
    chk("il_a_gnt", a_gnt_o, 1);
    tick();
    drv_a(0, 0, 0, 0, 0);
    drv_b(1, 0, 10'h020, 0, 4'hF);
    @(negedge clk_i);
    chk("il_b_gnt", b_gnt_o, 1);
    chk("il_a_ret", {a_rvalid_o, b_rvalid_o, a_rdata_o}, {2'b10, 32'h1111_1111});
    tick();
    drv_b(0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("il_b_ret", {a_rvalid_o, b_rvalid_o, b_rdata_o}, {2'b01, 32'h2222_2222});

    tick();
    drv_b(1, 1, 10'h3FF, 32'hAABB_CCDD, 4'b0011);
    @(negedge clk_i);
    chk("pw_cmd", {b_gnt_o, addr_o, wmask_o}, {1'b1, 10'h3FF, 4'b0011});
    tick();
    drv_b(1, 0, 10'h3FF, 0, 4'hF);
    @(negedge clk_i);
    chk("pr_gnt", b_gnt_o, 1);
    tick();
    drv_b(0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("pr_ret", {b_rvalid_o, b_rdata_o}, {1'b1, 32'h0000_CCDD});

    tick();
    drv_a(1, 1, 10'h007, 32'h1234_5678, 4'hF);
    tick();
    drv_a(1, 0, 10'h007, 0, 4'hF);
    tick();
    drv_a(0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("raw_ret", {a_rvalid_o, a_rdata_o}, {1'b1, 32'h1234_5678});

    tick();
    drv_b(1, 0, 10'h020, 0, 4'hF);
    @(negedge clk_i);
    chk("mr_gnt", b_gnt_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mr_rst_cmd", {csb_o, b_gnt_o}, 2'b10);
    chk("mr_rst_wait", dut.wait_cnt_q, 0);
    @(negedge clk_i);
    chk("mr_rst_rv", b_rvalid_o, 0);
    tick();
    rst_i = 1'b0;
    drv_b(0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("mr_post_rv", {a_rvalid_o, b_rvalid_o}, 2'b00);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
